fft_frame_loader: RTL



---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_frame_loader_if.sv | 41 ++++
 rtl/fft_frame_bank.sv | 47 ++++
 rtl/fft_frame_loader.sv | 110 +++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_pkg                                                          |
// | Purpose  : Shared constants, complex word type and bit-reverse helper for   |
// |            the 8-point FFT input path.                                      |
// | Contents : DATA_W, FFT_N, LOG2N, cplx_t, bitrev3()                          |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package fft_pkg;

  localparam int DATA_W = 9;
  localparam int FFT_N  = 8;
  localparam int LOG2N  = 3;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_frame_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_frame_loader_if                                              |
// | Purpose  : Sample-in stream and frame-out bus of the FFT frame loader.      |
// | Ports    : in_valid/in_ready/in_sof/in_re/in_im  - sample stream           |
// |            out_valid/out_ready/outr0..7/outi0..7 - parallel frame          |
// |            sof_err                              - resync pulse             |
// |            modport slave  : the loader                                      |
// |            modport master : upstream source plus downstream FFT stage       |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface fft_frame_loader_if;
  import fft_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic                     in_sof;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] outr0, outr1, outr2, outr3, outr4, outr5, outr6, outr7;
  logic signed [DATA_W-1:0] outi0, outi1, outi2, outi3, outi4, outi5, outi6, outi7;
  logic                     sof_err;

  modport slave (
    input  in_valid, in_sof, in_re, in_im, out_ready,
    output in_ready, out_valid, sof_err,
    output outr0, outr1, outr2, outr3, outr4, outr5, outr6, outr7,
    output outi0, outi1, outi2, outi3, outi4, outi5, outi6, outi7
  );

  modport master (
    output in_valid, in_sof, in_re, in_im, out_ready,
    input  in_ready, out_valid, sof_err,
    input  outr0, outr1, outr2, outr3, outr4, outr5, outr6, outr7,
    input  outi0, outi1, outi2, outi3, outi4, outi5, outi6, outi7
  );

endinterface
`default_nettype wire

// File: rtl/fft_frame_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_frame_bank                                                   |
// | Purpose  : One frame buffer: 8-entry complex register file with indexed     |
// |            write, a full flag with set/clear, and parallel read.            |
// | Ports    : clk, rst        - clock, asynchronous active-high reset          |
// |            i_wr_en/i_wr_slot/i_wr_data - single-word write                  |
// |            i_set_full/i_clr_full       - full flag control (set wins)       |
// |            o_full, o_rd_data           - flag and all 8 words              |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fft_frame_bank
  import fft_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_wr_en,
  input  wire logic [LOG2N-1:0] i_wr_slot,
  input  wire cplx_t            i_wr_data,
  input  wire logic             i_set_full,
  input  wire logic             i_clr_full,
  output logic                  o_full,
  output cplx_t [FFT_N-1:0]     o_rd_data
);

  cplx_t [FFT_N-1:0] r_mem;
  logic              r_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem  <= '0;
      r_full <= 1'b0;
    end else begin
      if (i_wr_en)
        r_mem[i_wr_slot] <= i_wr_data;
      if (i_set_full)
        r_full <= 1'b1;
      else if (i_clr_full)
        r_full <= 1'b0;
    end
  end

  assign o_full    = r_full;
  assign o_rd_data = r_mem;

endmodule
`default_nettype wire

// File: rtl/fft_frame_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_frame_loader                                                 |
// | Purpose  : Assembles 8 streamed complex samples into a frame and presents   |
// |            completed frames in parallel from a ping-pong pair of banks.     |
// | Ports    : clk, rst - clock, asynchronous active-high reset                 |
// |            bus      - fft_frame_loader_if.slave (stream in, frame out)      |
// | Config   : FFT_LOADER_BITREV_EN defined -> sample k lands in slot           |
// |            bitrev3(k); undefined -> natural order.                          |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fft_frame_loader
  import fft_pkg::*;
(
  input wire logic           clk,
  input wire logic           rst,
  fft_frame_loader_if.slave  bus
);

  logic [LOG2N-1:0]  r_wr_idx;
  logic              r_wr_sel;
  logic              r_rd_sel;
  logic              r_sof_err;

  logic [1:0]        w_full;
  cplx_t [FFT_N-1:0] w_rd [2];
  cplx_t [FFT_N-1:0] w_out;
  logic              w_accept;
  logic              w_resync;
  logic              w_complete;
  logic              w_consume;
  logic [LOG2N-1:0]  w_idx;
  logic [LOG2N-1:0]  w_slot;
  cplx_t             w_wr_data;

  // in_ready depends only on registered flags, so a consume this cycle
  // frees the writer no earlier than the next cycle.
  assign bus.in_ready  = !w_full[r_wr_sel];
  assign bus.out_valid = w_full[r_rd_sel];
  assign bus.sof_err   = r_sof_err;

  assign w_accept   = bus.in_valid && bus.in_ready;
  assign w_consume  = bus.out_valid && bus.out_ready;
  // A start-of-frame mid-frame restarts the frame: the sample goes to
  // position 0 and the stale slots are overwritten by the samples that follow.
  assign w_resync   = w_accept && bus.in_sof && (r_wr_idx != '0);
  assign w_idx      = w_resync ? '0 : r_wr_idx;
  assign w_complete = w_accept && (w_idx == LOG2N'(FFT_N - 1));
  assign w_wr_data  = '{re: bus.in_re, im: bus.in_im};

`ifdef FFT_LOADER_BITREV_EN
  assign w_slot = bitrev3(w_idx);
`else
  assign w_slot = w_idx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_idx  <= '0;
      r_wr_sel  <= 1'b0;
      r_rd_sel  <= 1'b0;
      r_sof_err <= 1'b0;
    end else begin
      r_sof_err <= w_resync;
      if (w_accept)
        r_wr_idx <= w_idx + 1'b1;   // wraps 7 -> 0 at frame end
      if (w_complete)
        r_wr_sel <= ~r_wr_sel;
      if (w_consume)
        r_rd_sel <= ~r_rd_sel;
    end
  end

  // Bank 0 is A, bank 1 is B. Set and clear never hit the same bank in one
  // cycle: completion needs the bank empty, consumption needs it full.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    fft_frame_bank u_bank (
      .clk        (clk),
      .rst        (rst),
      .i_wr_en    (w_accept && (r_wr_sel == 1'(gi))),
      .i_wr_slot  (w_slot),
      .i_wr_data  (w_wr_data),
      .i_set_full (w_complete && (r_wr_sel == 1'(gi))),
      .i_clr_full (w_consume && (r_rd_sel == 1'(gi))),
      .o_full     (w_full[gi]),
      .o_rd_data  (w_rd[gi])
    );
  end

  assign w_out = w_rd[r_rd_sel];

  assign bus.outr0 = w_out[0].re;
  assign bus.outr1 = w_out[1].re;
  assign bus.outr2 = w_out[2].re;
  assign bus.outr3 = w_out[3].re;
  assign bus.outr4 = w_out[4].re;
  assign bus.outr5 = w_out[5].re;
  assign bus.outr6 = w_out[6].re;
  assign bus.outr7 = w_out[7].re;
  assign bus.outi0 = w_out[0].im;
  assign bus.outi1 = w_out[1].im;
  assign bus.outi2 = w_out[2].im;
  assign bus.outi3 = w_out[3].im;
  assign bus.outi4 = w_out[4].im;
  assign bus.outi5 = w_out[5].im;
  assign bus.outi6 = w_out[6].im;
  assign bus.outi7 = w_out[7].im;

endmodule
`default_nettype wire
